// File: rtl/rv64im_pkg.sv
// Shared definitions for the RV64IM front end.
// Holds the architectural width, the default boot PC, the canonical NOP
// encoding and the fetch-stage state encoding used by rv64im_fetch_unit.
package rv64im_pkg;

  localparam int          XLEN             = 64;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/rv64im_fetch_fifo.sv
// Prefetch FIFO between the instruction memory response path and the core.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : drops every entry (takes priority over push/pop)
//   push       : write push_data at the tail
//   push_data  : entry to store ({instruction, pc} in the fetch unit)
//   pop        : remove the head entry (ignored when empty)
//   count      : number of valid entries, 0..DEPTH
//   head       : entry at the head; meaningless while count is 0
module rv64im_fetch_fifo
  import rv64im_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
  // pointers simply wrap. A simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array is left unreset; the head is only looked at when count
  // says it holds real data.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // The fetch unit's credit scheme must never let a write land on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !clear && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/rv64im_fetch_unit.sv
// Instruction fetch stage feeding the RV64IM execute core.
// Keeps the fetch PC, issues word reads to instruction memory (in-order
// responses, no response backpressure), buffers returned words with their PC
// in a prefetch FIFO and hands them to the core over a valid/ready pair.
// A redirect flushes the FIFO and discards responses already in flight.
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr  : memory read request channel (word address)
//   imem_resp_valid/data       : memory read response (always accepted)
//   redirect_valid/pc          : new fetch PC from the core (low 2 bits ignored)
//   inst_valid/ready           : instruction handshake towards the core
//   riscv_32bits_instruction   : instruction at the FIFO head
//   inst_pc                    : PC of that instruction
module rv64im_fetch_unit
  import rv64im_pkg::*;
#(
  parameter int              XLEN       = rv64im_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     riscv_32bits_instruction,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int CRD_W   = CNT_W + 1;
  localparam int ENTRY_W = 32 + XLEN;

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [XLEN-1:0]  redirect_target;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] fifo_count;
  logic [CRD_W-1:0] credits_used;
  logic             req_fire;
  logic             resp_counted;
  logic             fifo_push;
  logic             fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;

  assign redirect_target = redirect_pc & ~XLEN'(3);

  // Every word either sitting in the FIFO or still owed by memory holds a
  // slot, so a request only goes out when a slot is guaranteed for its
  // response. A redirect withdraws the request in the same cycle.
  assign credits_used   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = (state_q == RUN) && !redirect_valid
                          && (credits_used < CRD_W'(FIFO_DEPTH));
  assign imem_req_addr  = imem_req_valid ? fetch_pc : '0;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses always retire a credit; they are only kept in RUN and never in
  // a redirect cycle, because anything already requested belongs to the old
  // instruction stream.
  assign resp_counted     = imem_resp_valid && (outstanding != '0);
  assign fifo_push        = (state_q == RUN) && imem_resp_valid && !redirect_valid;
  assign outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(resp_counted);

  assign inst_valid = (fifo_count != '0);
  assign fifo_pop   = inst_valid && inst_ready;

  // Next-state selection. FLUSH waits for the last stale response to drain;
  // a redirect arriving while flushing only retargets the PC.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid && (outstanding_next != '0)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!redirect_valid && (outstanding_next == '0)) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State, credit counter and the two PC trackers. fetch_pc follows accepted
  // requests, resp_pc follows kept responses so each word is tagged with the
  // address it was fetched from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
    end else begin
      state_q     <= state_d;
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (fifo_push) begin
          resp_pc <= resp_pc + XLEN'(4);
        end
      end
    end
  end

  rv64im_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (fifo_push),
    .push_data ({imem_resp_data, resp_pc}),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign riscv_32bits_instruction = inst_valid ? fifo_head[ENTRY_W-1:XLEN] : '0;
  assign inst_pc                  = inst_valid ? fifo_head[XLEN-1:0] : '0;

endmodule

// File: tb/tb_rv64im_fetch_unit.sv
// Self-checking bench for rv64im_fetch_unit.
// A behavioural instruction memory answers each accepted request after
// mem_lat cycles. Every accepted request pushes the instruction the core
// should eventually see onto exp_q; a redirect empties exp_q (the popped
// head of that cycle is compared first). A separate monitor pops exp_q on
// every instruction handshake. Directed checks cover reset, back-pressure,
// stalls, flushing and asynchronous reset.
module tb_rv64im_fetch_unit;
  import rv64im_pkg::*;

  localparam logic [63:0] BOOT_PC = 64'h0000_0000_8000_0000;

  typedef struct {
    logic [63:0] addr;
    int          cyc;
  } pend_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] riscv_32bits_instruction;
  logic [63:0] inst_pc;

  pend_t pending[$];
  exp_t  exp_q[$];
  exp_t  mon_e;
  int    errors     = 0;
  int    checks     = 0;
  int    cyc        = 0;
  int    mem_lat    = 1;
  int    fire_count = 0;
  int    pop_count  = 0;
  logic  last_triple = 1'b0;

  rv64im_fetch_unit dut (
    .clk                      (clk),
    .rst                      (rst),
    .imem_req_valid           (imem_req_valid),
    .imem_req_ready           (imem_req_ready),
    .imem_req_addr            (imem_req_addr),
    .imem_resp_valid          (imem_resp_valid),
    .imem_resp_data           (imem_resp_data),
    .redirect_valid           (redirect_valid),
    .redirect_pc              (redirect_pc),
    .inst_valid               (inst_valid),
    .inst_ready               (inst_ready),
    .riscv_32bits_instruction (riscv_32bits_instruction),
    .inst_pc                  (inst_pc)
  );

  // Free-running clock: posedge at 5, 15, ...; stimulus changes on negedge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: a simple address-derived pattern.
  function automatic logic [31:0] mem_word(input logic [63:0] addr);
    return 32'hC0DE_0000 ^ addr[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // One clock cycle, entered and left on a negedge. Drives the memory
  // response for this cycle, records accepted requests and handshakes, and
  // empties the expectation queue after the monitor has seen a redirect cycle.
  task automatic step();
    pend_t p;
    if (pending.size() > 0 && (cyc - pending[0].cyc) >= mem_lat) begin
      p = pending.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(p.addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
    last_triple = redirect_valid && inst_valid && inst_ready && imem_resp_valid;
    if (redirect_valid) begin
      checkOutput("redirect_withdraws_req", imem_req_valid, 1'b0);
    end
    if (!rst && inst_valid && inst_ready) begin
      pop_count++;
    end
    if (imem_req_valid && imem_req_ready) begin
      fire_count++;
      pending.push_back('{imem_req_addr, cyc});
      exp_q.push_back('{mem_word(imem_req_addr), imem_req_addr});
    end
    #3;
    if (redirect_valid) begin
      exp_q.delete();
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [63:0] rpc,
                               input logic ir, input logic mr);
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = ir;
    imem_req_ready = mr;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic doReset();
    rst             = 1'b1;
    inst_ready      = 1'b0;
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    pending.delete();
    exp_q.delete();
    fire_count = 0;
    step();
    rst = 1'b0;
  endtask

  task automatic waitInstValid(input string name, input int budget);
    int n;
    n = 0;
    while (!inst_valid && n < budget) begin
      step();
      n++;
    end
    checkOutput(name, inst_valid, 1'b1);
  endtask

  // Scoreboard monitor: every instruction handshake must match the oldest
  // expected instruction, sampled 3 time units after the negedge.
  always begin
    @(negedge clk);
    #3;
    if (!rst && inst_valid && inst_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected: actual pc=%h inst=%h required no instruction",
                 inst_pc, riscv_32bits_instruction);
      end else begin
        mon_e = exp_q.pop_front();
        if (riscv_32bits_instruction !== mon_e.inst || inst_pc !== mon_e.pc) begin
          errors++;
          $display("[TB] FAIL sb_inst: actual pc=%h inst=%h required pc=%h inst=%h",
                   inst_pc, riscv_32bits_instruction, mon_e.pc, mon_e.inst);
        end
      end
    end
  end

  // Hard time limit so a stuck design can never hang the run.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    inst_ready      = 1'b0;
    @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_req_valid", imem_req_valid, 1'b0);
    checkOutput("rst_req_addr", imem_req_addr, 64'h0);
    checkOutput("rst_inst_valid", inst_valid, 1'b0);
    checkOutput("rst_inst", riscv_32bits_instruction, 32'h0);
    checkOutput("rst_inst_pc", inst_pc, 64'h0);
    rst = 1'b0;

    $display("[TB] streaming fetch");
    checkOutput("t1_boot_no_req", imem_req_valid, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
    checkOutput("t1_first_req_valid", imem_req_valid, 1'b1);
    checkOutput("t1_first_req_addr", imem_req_addr, BOOT_PC);
    waitInstValid("t1_inst_valid_timeout", 20);
    checkOutput("t1_first_inst_pc", inst_pc, BOOT_PC);
    runCycles(10);

    $display("[TB] core back-pressure");
    doReset();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    runCycles(12);
    checkOutput("t2_request_count", 64'(fire_count), 64'd4);
    checkOutput("t2_req_valid_low", imem_req_valid, 1'b0);
    checkOutput("t2_fifo_count", 64'(dut.fifo_count), 64'd4);
    checkOutput("t2_head_pc", inst_pc, BOOT_PC);
    pop_count = 0;
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
    runCycles(3);
    checkOutput("t2_drain_pops", 64'(pop_count), 64'd4);
    runCycles(6);
    checkOutput("t2_fetch_resumed", 64'(fire_count > 4), 64'd1);

    $display("[TB] redirect with responses in flight");
    doReset();
    mem_lat = 5;
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
    runCycles(3);
    checkOutput("t3_outstanding", 64'(dut.outstanding), 64'd3);
    applyStimulus(1'b1, 64'h0000_0000_8000_0103, 1'b1, 1'b1);
    checkOutput("t3_state_flush", 64'(dut.state_q), 64'(FLUSH));
    checkOutput("t3_flush_no_req", imem_req_valid, 1'b0);
    begin
      int n;
      n = 0;
      while (!imem_req_valid && n < 20) begin
        step();
        n++;
      end
      checkOutput("t3_flush_cycles", 64'(n), 64'd4);
    end
    checkOutput("t3_next_req_addr", imem_req_addr, 64'h0000_0000_8000_0100);
    checkOutput("t3_fifo_empty", 64'(dut.fifo_count), 64'd0);
    waitInstValid("t3_inst_valid_timeout", 20);
    checkOutput("t3_first_pc", inst_pc, 64'h0000_0000_8000_0100);
    runCycles(8);

    $display("[TB] memory stall");
    doReset();
    mem_lat = 1;
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_req_valid", imem_req_valid, 1'b1);
      checkOutput("t4_addr_stable", imem_req_addr, BOOT_PC);
      checkOutput("t4_no_outstanding", 64'(dut.outstanding), 64'd0);
      checkOutput("t4_fetch_pc_held", dut.fetch_pc, BOOT_PC);
      step();
    end
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
    checkOutput("t4_addr_advanced", imem_req_addr, 64'h0000_0000_8000_0004);
    checkOutput("t4_outstanding_one", 64'(dut.outstanding), 64'd1);

    $display("[TB] redirect with pop and response in the same cycle");
    runCycles(8);
    applyStimulus(1'b1, 64'h0000_0000_8000_0200, 1'b1, 1'b1);
    checkOutput("t5_triple_event", last_triple, 1'b1);
    checkOutput("t5_inst_valid_low", inst_valid, 1'b0);
    checkOutput("t5_state_run", 64'(dut.state_q), 64'(RUN));
    waitInstValid("t5_inst_valid_timeout", 20);
    checkOutput("t5_first_pc", inst_pc, 64'h0000_0000_8000_0200);
    runCycles(5);

    $display("[TB] asynchronous reset mid-operation");
    doReset();
    mem_lat = 3;
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    runCycles(5);
    checkOutput("t6_outstanding", 64'(dut.outstanding), 64'd2);
    checkOutput("t6_fifo_count", 64'(dut.fifo_count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_req_valid", imem_req_valid, 1'b0);
    checkOutput("t6_req_addr", imem_req_addr, 64'h0);
    checkOutput("t6_inst_valid", inst_valid, 1'b0);
    checkOutput("t6_inst", riscv_32bits_instruction, 32'h0);
    checkOutput("t6_inst_pc", inst_pc, 64'h0);
    @(negedge clk);
    cyc++;
    mem_lat = 1;
    doReset();
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
    checkOutput("t6_restart_valid", imem_req_valid, 1'b1);
    checkOutput("t6_restart_addr", imem_req_addr, BOOT_PC);
    runCycles(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
